fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage of the single-cycle MIPS core. Owns the PC and fetches one word at a
//   time from instruction memory over a req/valid handshake.
// - Presents opcode/func to the control unit and holds the instruction until the datapath retires it.
// - On retire, consumes branch/bne/jump/jr from control plus ALU zero and selects the next PC.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
// - AW        32             PC/address width; fixed at 32, exposed for the package only
// PORTS
// - clock        in   1   single clock, rising edge
// - reset_n      in   1   asynchronous, active-low reset
// - imem_req     out  1   fetch request; held high until imem_valid
// - imem_addr    out  32  word-aligned fetch address (== pc)
// - imem_valid   in   1   read data valid; any cycle >= 1 after imem_req rises
// - imem_rdata   in   32  instruction word
// - instr        out  32  held instruction
// - instr_valid  out  1   instr/opcode/func are valid for the datapath
// - opcode       out  6   instr[31:26], to control.opcode
// - func         out  6   instr[5:0], to control.func
// - pc_plus4     out  32  pc+4; link value for jal
// - instr_ack    in   1   datapath retires the held instruction this cycle
// - branch, bne  in   1   from control
// - jump, jr     in   1   from control
// - zero         in   1   ALU zero flag
// - jr_target    in   32  rs register value for jr
// - fetch_err    out  1   sticky: jr_target[1:0] != 0 was taken
// BEHAVIOUR
// - Reset (async, reset_n=0): pc=RESET_PC, state=S_IDLE, imem_req=0, instr=0, instr_valid=0,
//   fetch_err=0. The outputs opcode/func are 0 during reset.
// - FSM S_IDLE -> S_FETCH: 1 cycle after reset_n is released. imem_req=0 in S_IDLE.
// - S_FETCH: imem_req=1, imem_addr=pc. On imem_valid: instr<=imem_rdata, instr_valid<=1, go S_HOLD.
//   Best case, imem_valid is high in the cycle after the request; instr_valid rises the next cycle.
// - S_HOLD: instr_valid=1, imem_req=0. instr is frozen. When instr_ack=1: pc<=next_pc,
//   instr_valid<=0, go S_FETCH. Fetch-to-fetch minimum is 3 cycles.
// - next_pc is evaluated only on the ack cycle, with this priority:
//   jr -> {jr_target[31:2],2'b00} > jump -> {pc_plus4[31:28],instr[25:0],2'b00} >
//   taken -> pc_plus4 + (sext(instr[15:0])<<2) > pc_plus4.
// - taken = branch & (bne ? ~zero : zero). All adds are 32-bit and wrap modulo 2^32 with no flag.
// - jr with jr_target[1:0]!=0: the low bits are forced to 00 and fetch_err is set. fetch_err clears
//   only on reset.
// - Ignored inputs: imem_valid outside S_FETCH, and instr_ack outside S_HOLD.
// - Simultaneous imem_valid and instr_ack in S_FETCH: the ack is ignored and the data is captured.
// - Reset asserted mid-fetch: the outstanding response is discarded (the FSM is in S_IDLE) and
//   the fetch restarts from RESET_PC.
// - Control inputs with X (j/jal aluop etc.) must not reach pc. Only the listed signals feed next_pc.
// STRUCTURE
// - Shared package mips_pkg holds:
//   - OPC_* opcode constants and FUNC_JR;
//   - fetch state encoding S_IDLE=2'd0, S_FETCH=2'd1, S_HOLD=2'd2;
//   - RESET_PC default.
// - One sub-module, next_pc_sel: combinational target and priority mux (pc, instr, control, zero,
//   jr_target -> next_pc, misalign). The PC register, FSM and instr register stay in fetch_unit.
// TESTING
// - Reset and first fetch: release reset_n; imem_addr=0x0 with imem_req=1 on the 2nd cycle;
//   return 0x2008_0005 (addi) -> opcode=6'b001000, instr_valid=1.
// - Sequential: ack with no control -> next imem_addr=0x4; pc_plus4=0x8 after that fetch.
// - Branches at pc=0x10 with imm=0xFFFC:
//   - beq with zero=1 -> next 0x4;
//   - beq with zero=0 -> 0x14;
//   - bne with zero=0 -> 0x4.
// - Jumps:
//   - j with target 0x0000040 at pc=0x1000 -> 0x100;
//   - jr with jr_target=0x2002 -> 0x2000 and fetch_err=1 (sticky).
// - Handshake: imem_valid delayed 5 cycles -> imem_req stays high with a stable imem_addr.
//   Then a stray imem_valid and instr_ack in S_HOLD -> no state change.
// - Reset mid-fetch: drop reset_n while in S_FETCH, and assert imem_valid 1 cycle after release.
//   Required: instr_valid stays 0 and the refetch is from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch FSM encoding, reset PC.
// Imported by the fetch stage and its next-PC selector.
package mips_pkg;

    localparam int AW = 32;
    localparam logic [AW-1:0] DEF_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    localparam logic [5:0] FUNC_JR   = 6'h08;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [AW-1:0] br_off(input logic [15:0] imm);
        br_off = {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target generation and priority select for the fetch stage.
// Only the listed control inputs can steer the PC.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        taken;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + br_off(instr[15:0]);
    assign j_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign taken    = branch & (bne ? ~zero : zero);
    assign misalign = jr & (|jr_target[1:0]);

    // jr wins over jump, which wins over a taken branch
    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = {jr_target[31:2], 2'b00};
        else if (jump)
            next_pc = j_tgt;
        else if (taken)
            next_pc = br_tgt;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/valid handshake,
// held instruction and next-PC update on retire.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         misalign;

    next_pc_sel u_sel (
        .pc        (pc),
        .instr     (instr),
        .branch    (branch),
        .bne       (bne),
        .jump      (jump),
        .jr        (jr),
        .zero      (zero),
        .jr_target (jr_target),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign func      = instr[5:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                        if (misalign)
                            fetch_err <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
